// File: rtl/hazard_sb.sv
// N-lane hazard unit: M/W forwarding selects, load-use/ecall interlocks and a long-latency scoreboard.
// Define HAZARD_PERF_EN to add the PerfMemStall/PerfDataStall stall-cycle counters.
module hazard_sb #(
  parameter int LANES     = 2,
  parameter int NREG      = 32,
  parameter int ECALL_REG = 10,
  parameter int SELW      = (LANES < 2) ? 3 : 2 + $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enableD,
  input  logic                    PCSrcE,
  input  logic [LANES-1:0]        Stall_miss,
  input  logic [LANES*5-1:0]      Rs1D,
  input  logic [LANES*5-1:0]      Rs2D,
  input  logic [LANES*5-1:0]      RdD,
  input  logic [LANES*5-1:0]      Rs1E,
  input  logic [LANES*5-1:0]      Rs2E,
  input  logic [LANES*5-1:0]      RdE,
  input  logic [LANES-1:0]        ResultSrcE0,
  input  logic [LANES-1:0]        EcallE,
  input  logic [LANES-1:0]        EcallM,
  input  logic [LANES-1:0]        LongIssueE,
  input  logic                    LongDone,
  input  logic [4:0]              LongDoneRd,
  input  logic [LANES*5-1:0]      RdM,
  input  logic [LANES*5-1:0]      RdW,
  input  logic [LANES-1:0]        RegWriteM,
  input  logic [LANES-1:0]        RegWriteW,
  output logic [LANES*SELW-1:0]   FwdAE,
  output logic [LANES*SELW-1:0]   FwdBE,
  output logic                    StallF,
  output logic                    StallD,
  output logic                    StallE,
  output logic                    StallM,
  output logic                    StallW,
  output logic                    FlushD,
  output logic                    FlushE,
  output logic [NREG-1:0]         SbBusy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]             PerfMemStall,
  output logic [31:0]             PerfDataStall
`endif
);

  localparam int LW = SELW - 2;

  logic [4:0] rs1_d [LANES];
  logic [4:0] rs2_d [LANES];
  logic [4:0] rd_d  [LANES];
  logic [4:0] rs1_e [LANES];
  logic [4:0] rs2_e [LANES];
  logic [4:0] rd_e  [LANES];
  logic [4:0] rd_m  [LANES];
  logic [4:0] rd_w  [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign rs1_d[g] = Rs1D[g*5 +: 5];
    assign rs2_d[g] = Rs2D[g*5 +: 5];
    assign rd_d[g]  = RdD[g*5 +: 5];
    assign rs1_e[g] = Rs1E[g*5 +: 5];
    assign rs2_e[g] = Rs2E[g*5 +: 5];
    assign rd_e[g]  = RdE[g*5 +: 5];
    assign rd_m[g]  = RdM[g*5 +: 5];
    assign rd_w[g]  = RdW[g*5 +: 5];
  end

  logic            stall;
  logic            load_hz;
  logic            ecall_hz;
  logic            sb_hz;
  logic            data_hz;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  assign stall = |Stall_miss;

  // Later assignments win: W before M, ascending lane so the youngest producer overrides.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no latch is inferred.
    FwdAE = '0;
    FwdBE = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < LANES; j++) begin
        if (RegWriteW[j] && rs1_e[i] != 5'd0 && rs1_e[i] == rd_w[j])
          FwdAE[i*SELW +: SELW] = {LW'(j), 2'b01};
        if (RegWriteW[j] && rs2_e[i] != 5'd0 && rs2_e[i] == rd_w[j])
          FwdBE[i*SELW +: SELW] = {LW'(j), 2'b01};
      end
      for (int j = 0; j < LANES; j++) begin
        if (RegWriteM[j] && rs1_e[i] != 5'd0 && rs1_e[i] == rd_m[j])
          FwdAE[i*SELW +: SELW] = {LW'(j), 2'b10};
        if (RegWriteM[j] && rs2_e[i] != 5'd0 && rs2_e[i] == rd_m[j])
          FwdBE[i*SELW +: SELW] = {LW'(j), 2'b10};
      end
    end
  end

  always_comb begin
    load_hz  = 1'b0;
    ecall_hz = 1'b0;
    sb_hz    = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < LANES; j++) begin
        if (ResultSrcE0[j] && rd_e[j] != 5'd0 &&
            (rs1_d[i] == rd_e[j] || rs2_d[i] == rd_e[j]))
          load_hz = 1'b1;
        // Issue in flight this cycle: not yet visible in the scoreboard.
        if (LongIssueE[j] && rd_e[j] != 5'd0 &&
            (rs1_d[i] == rd_e[j] || rs2_d[i] == rd_e[j] || rd_d[i] == rd_e[j]))
          sb_hz = 1'b1;
      end
      if (rs1_d[i] == 5'(ECALL_REG) || rs2_d[i] == 5'(ECALL_REG))
        ecall_hz = 1'b1;
      for (int r = 1; r < NREG; r++) begin
        if (busy_q[r] && (rs1_d[i] == 5'(r) || rs2_d[i] == 5'(r) || rd_d[i] == 5'(r)))
          sb_hz = 1'b1;
      end
    end
    load_hz  = load_hz & enableD;
    ecall_hz = ecall_hz & enableD & (|(EcallE | EcallM));
    sb_hz    = sb_hz & enableD;
  end

  assign data_hz = load_hz | ecall_hz | sb_hz;

  assign StallF = data_hz | stall;
  assign StallD = data_hz | stall;
  assign StallE = stall;
  assign StallM = stall;
  assign StallW = stall;
  assign FlushD = !stall & PCSrcE;
  assign FlushE = !stall & (PCSrcE | data_hz);

  // Clear first, then set: a new issue to the same register outranks the older completion.
  always_comb begin
    busy_d = busy_q;
    if (LongDone) begin
      for (int r = 1; r < NREG; r++)
        if (LongDoneRd == 5'(r)) busy_d[r] = 1'b0;
    end
    if (!stall) begin
      for (int j = 0; j < LANES; j++)
        for (int r = 1; r < NREG; r++)
          if (LongIssueE[j] && rd_e[j] == 5'(r)) busy_d[r] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign SbBusy = busy_q;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PerfMemStall  <= '0;
      PerfDataStall <= '0;
    end else begin
      if (stall)            PerfMemStall  <= PerfMemStall + 32'd1;
      if (data_hz && !stall) PerfDataStall <= PerfDataStall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_sb.sv
// Scoreboard bench for hazard_sb (LANES=2): expected snapshots queued at drive time, popped at negedge.
module tb_hazard_sb;
  localparam int LANES = 2;
  localparam int NREG  = 32;
  localparam int SELW  = 3;

  // ctl = {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE}
  localparam logic [6:0] QUIET = 7'b0000000;
  localparam logic [6:0] HAZ   = 7'b1100001;
  localparam logic [6:0] MEM   = 7'b1111100;
  localparam logic [6:0] REDIR = 7'b0000011;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  enableD, PCSrcE;
  logic [LANES-1:0]      Stall_miss;
  logic [LANES*5-1:0]    Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [LANES-1:0]      ResultSrcE0, EcallE, EcallM, LongIssueE, RegWriteM, RegWriteW;
  logic                  LongDone;
  logic [4:0]            LongDoneRd;
  logic [LANES*SELW-1:0] FwdAE, FwdBE;
  logic                  StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
  logic [NREG-1:0]       SbBusy;

  always #5 clk = ~clk;

  hazard_sb #(.LANES(LANES), .NREG(NREG), .ECALL_REG(10)) dut (
    .clk(clk), .rst_n(rst_n), .enableD(enableD), .PCSrcE(PCSrcE), .Stall_miss(Stall_miss),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .EcallE(EcallE), .EcallM(EcallM), .LongIssueE(LongIssueE),
    .LongDone(LongDone), .LongDoneRd(LongDoneRd), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .FwdAE(FwdAE), .FwdBE(FwdBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE), .SbBusy(SbBusy)
  );

  typedef struct packed {
    logic [6:0]            ctl;
    logic [NREG-1:0]       busy;
    logic [LANES*SELW-1:0] fa;
    logic [LANES*SELW-1:0] fb;
  } snap_t;

  snap_t exp_q[$];
  snap_t got;
  int    total = 0;
  int    bad   = 0;

  assign got = {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, SbBusy, FwdAE, FwdBE};

  function automatic snap_t snap(logic [6:0] c, logic [31:0] b, logic [5:0] fa, logic [5:0] fb);
    return {c, b, fa, fb};
  endfunction

  task automatic idle;
    enableD = 0; PCSrcE = 0; Stall_miss = '0;
    Rs1D = '0; Rs2D = '0; RdD = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    ResultSrcE0 = '0; EcallE = '0; EcallM = '0; LongIssueE = '0; RegWriteM = '0; RegWriteW = '0;
    LongDone = 0; LongDoneRd = '0;
  endtask

  task automatic test_reset;
    snap_t e;
    rst_n = 0;
    idle();
    @(posedge clk); #1;
    exp_q.push_back(snap(QUIET, 32'h0, '0, '0));
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL reset: got ctl=%b busy=%h fa=%b fb=%b want ctl=%b busy=%h fa=%b fb=%b",
               got.ctl, got.busy, got.fa, got.fb, e.ctl, e.busy, e.fa, e.fb);
    end
    rst_n = 1;
  endtask

  task automatic test_forward;
    logic [9:0] rs1e [8] = '{{5'd0,5'd5}, 10'd0, 10'd0, {5'd6,5'd0}, {5'd0,5'd5}, {5'd7,5'd0}, {5'd0,5'd3}, 10'd0};
    logic [9:0] rs2e [8] = '{10'd0, 10'd0, {5'd5,5'd0}, 10'd0, 10'd0, {5'd0,5'd7}, 10'd0, {5'd0,5'd4}};
    logic [9:0] rdm  [8] = '{{5'd5,5'd0}, {5'd5,5'd0}, 10'd0, 10'd0, {5'd5,5'd0}, {5'd7,5'd7}, {5'd0,5'd3}, {5'd0,5'd4}};
    logic [1:0] rwm  [8] = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 2'b01};
    logic [9:0] rdw  [8] = '{{5'd0,5'd5}, {5'd0,5'd5}, {5'd0,5'd5}, {5'd6,5'd6}, {5'd0,5'd5}, 10'd0, 10'd0, {5'd4,5'd0}};
    logic [1:0] rww  [8] = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b01, 2'b00, 2'b00, 2'b10};
    logic [5:0] xfa  [8] = '{6'b000110, 6'b000000, 6'b000000, 6'b101000, 6'b000001, 6'b110000, 6'b000010, 6'b000000};
    logic [5:0] xfb  [8] = '{6'b000000, 6'b000000, 6'b001000, 6'b000000, 6'b000000, 6'b000110, 6'b000000, 6'b000010};
    snap_t e;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      idle();
      Rs1E = rs1e[k]; Rs2E = rs2e[k]; RdM = rdm[k]; RegWriteM = rwm[k]; RdW = rdw[k]; RegWriteW = rww[k];
      exp_q.push_back(snap(QUIET, 32'h0, xfa[k], xfb[k]));
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL fwd[%0d]: got ctl=%b busy=%h fa=%b fb=%b want ctl=%b busy=%h fa=%b fb=%b",
                 k, got.ctl, got.busy, got.fa, got.fb, e.ctl, e.busy, e.fa, e.fb);
      end
    end
  endtask

  task automatic test_load_use;
    logic [1:0] res [5] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
    logic [9:0] rde [5] = '{{5'd7,5'd0}, {5'd7,5'd0}, 10'd0, {5'd7,5'd0}, {5'd0,5'd7}};
    logic [9:0] rs2 [5] = '{{5'd0,5'd7}, {5'd0,5'd7}, 10'd0, {5'd0,5'd7}, 10'd0};
    logic [9:0] rs1 [5] = '{10'd0, 10'd0, 10'd0, 10'd0, {5'd7,5'd0}};
    logic       en  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [6:0] xc  [5] = '{HAZ, QUIET, QUIET, QUIET, 7'b1100011};
    snap_t e;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      idle();
      ResultSrcE0 = res[k]; RdE = rde[k]; Rs1D = rs1[k]; Rs2D = rs2[k]; enableD = en[k];
      PCSrcE = (k == 4);
      exp_q.push_back(snap(xc[k], 32'h0, '0, '0));
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL load[%0d]: got ctl=%b busy=%h fa=%b fb=%b want ctl=%b busy=%h fa=%b fb=%b",
                 k, got.ctl, got.busy, got.fa, got.fb, e.ctl, e.busy, e.fa, e.fb);
      end
    end
  endtask

  task automatic test_ecall;
    logic [1:0] ece [4] = '{2'b00, 2'b10, 2'b10, 2'b00};
    logic [1:0] ecm [4] = '{2'b01, 2'b00, 2'b00, 2'b01};
    logic [9:0] rs1 [4] = '{{5'd10,5'd0}, 10'd0, 10'd0, {5'd10,5'd0}};
    logic [9:0] rs2 [4] = '{10'd0, {5'd0,5'd10}, {5'd0,5'd11}, 10'd0};
    logic       en  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [6:0] xc  [4] = '{HAZ, HAZ, QUIET, QUIET};
    snap_t e;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      idle();
      EcallE = ece[k]; EcallM = ecm[k]; Rs1D = rs1[k]; Rs2D = rs2[k]; enableD = en[k];
      exp_q.push_back(snap(xc[k], 32'h0, '0, '0));
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL ecall[%0d]: got ctl=%b busy=%h fa=%b fb=%b want ctl=%b busy=%h fa=%b fb=%b",
                 k, got.ctl, got.busy, got.fa, got.fb, e.ctl, e.busy, e.fa, e.fb);
      end
    end
  endtask

  // Issue x9 at t0, writeback at t5; the dependent bundle waits t0..t5 (WAW check at t3).
  task automatic test_long_latency;
    snap_t e;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      idle();
      enableD = 1;
      if (k == 3) RdD = {5'd0, 5'd9};
      else        Rs1D = {5'd9, 5'd0};
      if (k == 0) begin LongIssueE = 2'b01; RdE = {5'd0, 5'd9}; end
      if (k == 5) begin LongDone = 1; LongDoneRd = 5'd9; end
      exp_q.push_back(snap((k < 6) ? HAZ : QUIET, (k >= 1 && k <= 5) ? 32'h200 : 32'h0, '0, '0));
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL long[%0d]: got ctl=%b busy=%h fa=%b fb=%b want ctl=%b busy=%h fa=%b fb=%b",
                 k, got.ctl, got.busy, got.fa, got.fb, e.ctl, e.busy, e.fa, e.fb);
      end
    end
  endtask

  task automatic test_set_clear_race;
    logic       iss [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       dn  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [4:0] drd [6] = '{5'd0, 5'd9, 5'd0, 5'd9, 5'd12, 5'd0};
    logic [31:0] xb [6] = '{32'h0, 32'h200, 32'h200, 32'h200, 32'h0, 32'h0};
    snap_t e;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      idle();
      LongIssueE = {1'b0, iss[k]}; RdE = {5'd0, 5'd9}; LongDone = dn[k]; LongDoneRd = drd[k];
      exp_q.push_back(snap(QUIET, xb[k], '0, '0));
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL race[%0d]: got ctl=%b busy=%h fa=%b fb=%b want ctl=%b busy=%h fa=%b fb=%b",
                 k, got.ctl, got.busy, got.fa, got.fb, e.ctl, e.busy, e.fa, e.fb);
      end
    end
  endtask

  task automatic test_mem_stall;
    logic [6:0]  xc [6] = '{MEM, MEM, QUIET, MEM, QUIET, REDIR};
    logic [31:0] xb [6] = '{32'h0, 32'h0, 32'h0, 32'h8, 32'h0, 32'h0};
    snap_t e;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      idle();
      case (k)
        0: begin Stall_miss = 2'b10; PCSrcE = 1; LongIssueE = 2'b01; RdE = {5'd0, 5'd4}; end
        1: begin Stall_miss = 2'b10; enableD = 1; ResultSrcE0 = 2'b01; RdE = {5'd0, 5'd8}; Rs1D = {5'd0, 5'd8}; end
        2: begin LongIssueE = 2'b01; RdE = {5'd0, 5'd3}; end
        3: begin Stall_miss = 2'b01; LongDone = 1; LongDoneRd = 5'd3; end
        5: PCSrcE = 1;
        default: ;
      endcase
      exp_q.push_back(snap(xc[k], xb[k], '0, '0));
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL mem[%0d]: got ctl=%b busy=%h fa=%b fb=%b want ctl=%b busy=%h fa=%b fb=%b",
                 k, got.ctl, got.busy, got.fa, got.fb, e.ctl, e.busy, e.fa, e.fb);
      end
    end
  endtask

  // Reset asserted between edges while a dependent bundle is held on busy x3.
  task automatic test_reset_mid_stall;
    snap_t e;
    for (int k = 0; k < 4; k++) begin
      if (k != 2) begin
        @(posedge clk); #1;
        idle();
      end
      case (k)
        0: begin LongIssueE = 2'b01; RdE = {5'd0, 5'd3}; end
        1: begin Stall_miss = 2'b01; enableD = 1; Rs1D = {5'd0, 5'd3}; end
        2: begin #2; rst_n = 0; end
        3: begin enableD = 1; Rs1D = {5'd0, 5'd3}; end
        default: ;
      endcase
      case (k)
        0:       exp_q.push_back(snap(QUIET, 32'h0, '0, '0));
        1:       exp_q.push_back(snap(MEM, 32'h8, '0, '0));
        2:       exp_q.push_back(snap(MEM, 32'h0, '0, '0));
        default: exp_q.push_back(snap(QUIET, 32'h0, '0, '0));
      endcase
      if (k == 2) #1;
      else        @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL rstmid[%0d]: got ctl=%b busy=%h fa=%b fb=%b want ctl=%b busy=%h fa=%b fb=%b",
                 k, got.ctl, got.busy, got.fa, got.fb, e.ctl, e.busy, e.fa, e.fb);
      end
      if (k == 2) rst_n = 1;
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_ecall();
    test_long_latency();
    test_set_clear_race();
    test_mem_stall();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_sb.md
# hazard_sb

Parametrised hazard unit for the N-issue in-order pipeline; it supersedes the fixed dual-lane hazard logic. It generates per-lane ALU forwarding selects from M/W and detects load-use and ecall hazards across all lanes. It also adds a registered scoreboard that tracks destination registers of in-flight long-latency operations (mul/div unit), stalling dependent decode bundles until the result writes back. It sits beside the pipeline registers and drives all stall and flush controls.

## Interface
Parameters:
- LANES, 2, issue width (1..4).
- NREG, 32, architectural register count; x0 is never tracked or forwarded.
- ECALL_REG, 10, register read by ecall handling (a0).
- SELW, 2+$clog2(LANES) (min 3), forward-select width: [1:0] stage, upper bits lane index.

Ports (per-lane buses are flattened, lane i at slice i):
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- enableD  in  1  decode bundle valid.
- PCSrcE  in  1  branch/jump redirect from E.
- Stall_miss  in  LANES  AXI memory wait per lane.
- Rs1D, Rs2D, RdD  in  LANES*5  decode sources/destination.
- Rs1E, Rs2E, RdE  in  LANES*5  execute sources/destination.
- ResultSrcE0  in  LANES  load in E.
- EcallE, EcallM  in  LANES  ecall in E / M.
- LongIssueE  in  LANES  long-latency op in E, destination RdE.
- LongDone  in  1  long unit writeback this cycle.
- LongDoneRd  in  5  destination of completing op.
- RdM, RdW  in  LANES*5; RegWriteM, RegWriteW  in  LANES.
- FwdAE, FwdBE  out  LANES*SELW  forward selects.
- StallF, StallD, StallE, StallM, StallW, FlushD, FlushE  out  1.
- SbBusy  out  NREG  scoreboard busy bits (bit 0 tied 0).

## Operation
- Forward select: stage code 00 = register file, 10 = M, 01 = W; lane field = producing lane. Match requires Rs != 0, equal Rd, RegWrite. Priority: M over W; within a stage, higher lane index wins (youngest). LANES=2 reproduces legacy codes 110/010/101/001.
- Mem stall: Stall = OR(Stall_miss). StallE/M/W = Stall.
- loadHazard = enableD & any lane j ResultSrcE0[j] & any D source equal to RdE[j] (Rd != 0).
- ecallHazard = enableD & any (EcallE|EcallM) & any D source == ECALL_REG.
- sbHazard = enableD & any D source or RdD (WAW) with SbBusy set, or equal to RdE of a lane with LongIssueE (issue in flight this cycle).
- StallF = StallD = loadHazard | ecallHazard | sbHazard | Stall.
- FlushD = !Stall & PCSrcE; FlushE = !Stall & (PCSrcE | loadHazard | ecallHazard | sbHazard).
- Scoreboard: on clk, if !Stall, set busy[RdE[j]] for each LongIssueE[j] with RdE != 0. If LongDone, clear busy[LongDoneRd]. If the same register is both set and cleared, set wins (newer op). LongDone is honoured even during Stall.
- LongDone for a non-busy register: no-op.

## Timing
- Forward selects and stall/flush are combinational, same cycle.
- Scoreboard update takes 1 cycle: busy is visible the cycle after issue. The same-cycle path is covered by the LongIssueE term of sbHazard.
- A dependent bundle is released in the cycle after LongDone. Forwarding from W covers the writeback.
- Reset (async, any time): SbBusy = 0. All outputs follow from the inputs with the cleared scoreboard; no other state.

## Configuration
- HAZARD_PERF_EN defined: adds outputs PerfMemStall, PerfDataStall (32-bit each), reset 0. The counters increment per cycle of Stall and of (loadHazard|ecallHazard|sbHazard)&!Stall respectively, and wrap at 2^32.
- Undefined: no counters, ports absent.

## Test plan
- LANES=2, Rs1E0=5, RdM1=5, RegWriteM1, RdW0=5, RegWriteW0 -> FwdAE lane0 = 3'b110. Rs1E0=0 with the same writers -> 000.
- Load in E lane1 RdE1=7, Rs2D0=7, enableD -> StallF/StallD=1, FlushE=1, FlushD=0 for one cycle.
- LongIssueE0, RdE0=9 at t0; LongDone, LongDoneRd=9 at t5; Rs1D1=9 from t0 -> stall t0..t5, release t6, SbBusy[9] 1 over t1..t5.
- LongDone for reg 9 and LongIssueE for reg 9 in the same cycle -> SbBusy[9] stays 1.
- Stall_miss[1]=1 with PCSrcE=1 -> all Stall*=1, FlushD=FlushE=0; SbBusy unchanged by LongIssueE.
- Assert rst_n=0 mid-stall with SbBusy[3]=1 -> SbBusy=0 immediately, StallD=0 once the inputs are quiet.
